booth_multiplier: RTL and testbench
===================================

# booth_multiplier

Sequential signed two's-complement multiplier: radix-2 Booth, one multiplier bit retired per clock, 32×32 → 64-bit product. It is the multiply counterpart to the signed non-restoring divider in the ALU arithmetic path (ALU/Arith/Signed). It is driven by the ALU control with a start/done handshake. Operands are captured at start, so the requester may change them freely afterwards.

## Interface
- WIDTH, 32, operand width; product is 2×WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  in  1  request; sampled only when busy=0.
- multiplicand  in  WIDTH  signed operand M; captured on accepted start.
- multiplier  in  WIDTH  signed operand Q; captured on accepted start.
- busy  out  1  high while iterating (RUN state).
- done  out  1  one-cycle pulse; product valid.
- product  out  2×WIDTH  signed M×Q; held until next accepted start.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1, accepted:
  - load A=0 (WIDTH+1 bits), Q=multiplier, q_m1=0, M=sign-extended multiplicand (WIDTH+1 bits), count=0.
  - Go to RUN.
- RUN, each cycle:
  - Examine {Q[0], q_m1}: 01 → A=A+M; 10 → A=A−M; 00/11 → A unchanged.
  - Arithmetic-shift {A,Q,q_m1} right by one; A's sign bit is replicated.
  - count=count+1.
  - When count=WIDTH−1 at the edge: register product={A,Q}[2×WIDTH−1:0] from the post-shift value, go to DONE.
- DONE: done=1 for this cycle.
  - Go to IDLE, unless start=1, which is accepted exactly as from IDLE (back-to-back).
- start while busy=1: ignored; no effect on state, operands or outputs.
- Width rule: A is WIDTH+1 bits, so A−M with M=−2^(WIDTH−1) cannot overflow. −2^31 × −2^31 = 0x4000_0000_0000_0000 exactly.
- No overflow flag: the 64-bit product is always exact.

## Timing
- Reset values: busy=0, done=0, product=0, state=IDLE, count=0, A/Q/M/q_m1=0.
- Start accepted at edge k:
  - busy=1 after edge k through edge k+WIDTH.
  - product updated and done=1 after edge k+WIDTH, i.e. 32 cycles after acceptance.
  - busy=0 in the done cycle.
- Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- Reset mid-RUN: abort; next cycle equals the reset state, product=0, no done pulse. A start in the cycle after reset is deasserted is accepted normally.
- reset and start in the same cycle: reset wins; start is not accepted.
- product changes only on the RUN→DONE edge, or on reset.

## Structure
- Package booth_mult_pkg:
  - WIDTH default (32).
  - CNT_W = $clog2(WIDTH).
  - state enum {IDLE, RUN, DONE}.
- One sub-module, booth_step, combinational:
  - Inputs: A, Q, q_m1, M.
  - Outputs: next A, Q, q_m1 (Booth add/sub, then arithmetic shift).
  - Subtraction is done as A + ~M + 1 through the same adder.
- Top holds the FSM, the counter and the registers.

## Test plan
- 7 × −3: start with multiplicand=0x0000_0007, multiplier=0xFFFF_FFFD → done at 32 cycles after acceptance, product=0xFFFF_FFFF_FFFF_FFEB.
- 0x8000_0000 × 0x8000_0000 → product=0x4000_0000_0000_0000. Also 0x8000_0000 × 0x7FFF_FFFF → product=0xC000_0000_8000_0000.
- −1 × 1 → product=0xFFFF_FFFF_FFFF_FFFF. 0 × 0x1234_5678 → product=0; done still at 32 cycles after acceptance.
- start pulsed again at RUN cycle 5 with different operands, and operands changed mid-run → ignored; the original result appears, single done pulse.
- reset asserted at RUN cycle 10 → next cycle busy=0, done=0, product=0, no later done. A fresh 5×6 then yields product=30 at the normal latency.
- start held high in the DONE cycle with 2×3 after a prior 4×5 → done for 20, busy=1 next cycle, then done for 6 exactly 32 cycles later.

Source files
------------

// File: rtl/booth_mult_pkg.sv
// Shared width, counter width and FSM state encoding for the Booth multiplier.
package booth_mult_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of {A, Q, q_m1}. Purely combinational.
module booth_step
  import booth_mult_pkg::*;
#(
  parameter int N = WIDTH
) (
  input  logic [N:0]   i_a,
  input  logic [N-1:0] i_q,
  input  logic         i_q_m1,
  input  logic [N:0]   i_m,
  output logic [N:0]   o_a,
  output logic [N-1:0] o_q,
  output logic         o_q_m1
);

  logic         w_sub;
  logic         w_en;
  logic [N:0]   w_addend;
  logic [N:0]   w_sum;

  // {Q0,q_m1} = 10 subtracts, 01 adds, 00/11 leaves A alone.
  assign w_sub    = i_q[0] & ~i_q_m1;
  assign w_en     = i_q[0] ^ i_q_m1;

  // Subtraction shares the adder: A + ~M + 1.
  assign w_addend = w_sub ? ~i_m : i_m;
  assign w_sum    = w_en ? (i_a + w_addend + {{N{1'b0}}, w_sub}) : i_a;

  // A is N+1 bits wide, so its top bit is the true sign even for -2^(N-1).
  assign o_a      = {w_sum[N], w_sum[N:1]};
  assign o_q      = {w_sum[0], i_q[N-1:1]};
  assign o_q_m1   = i_q[0];

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed multiplier, one Booth step per clock. Operands are captured
// when start is accepted; the product register only changes on completion or
// reset.
module booth_multiplier
  import booth_mult_pkg::*;
#(
  parameter int N = WIDTH
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_start,
  input  logic [N-1:0]   i_multiplicand,
  input  logic [N-1:0]   i_multiplier,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*N-1:0] o_product
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t         r_state;
  state_t         w_state_next;
  logic [N:0]     r_a;
  logic [N:0]     r_m;
  logic [N-1:0]   r_q;
  logic           r_q_m1;
  logic [CW-1:0]  r_count;
  logic [2*N-1:0] r_product;

  logic [N:0]     w_a_next;
  logic [N-1:0]   w_q_next;
  logic           w_q_m1_next;
  logic           w_accept;
  logic           w_last;

  booth_step #(.N(N)) u_step (
    .i_a    (r_a),
    .i_q    (r_q),
    .i_q_m1 (r_q_m1),
    .i_m    (r_m),
    .o_a    (w_a_next),
    .o_q    (w_q_next),
    .o_q_m1 (w_q_m1_next)
  );

  assign w_last    = (r_count == CW'(N - 1));
  assign o_product = r_product;

  // State register; reset dominates any start in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, start acceptance and status outputs.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        o_busy = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        o_done = 1'b1;
        if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Operand capture, per-cycle Booth iteration and product latch on the final step.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a       <= '0;
      r_q       <= '0;
      r_q_m1    <= 1'b0;
      r_m       <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_a       <= '0;
      r_q       <= i_multiplier;
      r_q_m1    <= 1'b0;
      r_m       <= {i_multiplicand[N-1], i_multiplicand};
      r_count   <= '0;
    end else if (r_state == RUN) begin
      r_a       <= w_a_next;
      r_q       <= w_q_next;
      r_q_m1    <= w_q_m1_next;
      r_count   <= r_count + 1'b1;
      if (w_last) begin
        r_product <= {w_a_next[N-1:0], w_q_next};
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier: expected products and acceptance
// cycles are queued at start, and popped when done is observed.
module tb_booth_multiplier;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [31:0] i_multiplicand;
  logic [31:0] i_multiplier;
  logic        o_busy;
  logic        o_done;
  logic [63:0] o_product;

  int          n_chk    = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  int          d0;
  int          n_wait;
  logic [63:0] exp_q[$];
  int          acc_q[$];
  logic [63:0] last_exp = '0;
  logic [63:0] mon_exp;
  int          mon_acc;
  logic [31:0] rm, rq;

  booth_multiplier dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_product      (o_product)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic [31:0] m, input logic [31:0] q);
    logic signed [63:0] sm;
    logic signed [63:0] sq;
    sm = {{32{m[31]}}, m};
    sq = {{32{q[31]}}, q};
    return sm * sq;
  endfunction

  // Called at a negedge; start is accepted at the following posedge.
  task automatic launch(input logic [31:0] m, input logic [31:0] q, input logic [63:0] exp);
    i_multiplicand = m;
    i_multiplier   = q;
    i_start        = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    exp_q.push_back(exp);
    acc_q.push_back(cyc);
    check_val("busy_after_start", {63'd0, o_busy}, 64'd1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_val("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      acc_q.delete();
    end
    repeat (3) @(negedge i_clk);
    check_val("product_hold", o_product, last_exp);
  endtask

  always @(negedge i_clk) begin
    if (o_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_val("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_acc = acc_q.pop_front();
        check_val("product", o_product, mon_exp);
        check_val("latency", 64'(cyc - mon_acc), 64'd32);
        check_val("busy_in_done", {63'd0, o_busy}, 64'd0);
        last_exp = mon_exp;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1);
  end

  initial begin
    i_reset        = 1'b1;
    i_start        = 1'b0;
    i_multiplicand = '0;
    i_multiplier   = '0;
    repeat (3) @(negedge i_clk);
    check_val("rst_busy", {63'd0, o_busy}, 64'd0);
    check_val("rst_done", {63'd0, o_done}, 64'd0);
    check_val("rst_product", o_product, 64'd0);
    i_reset = 1'b0;
    @(negedge i_clk);

    launch(32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB); drain(40);
    launch(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000); drain(40);
    launch(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000); drain(40);
    launch(32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF); drain(40);
    launch(32'h0000_0000, 32'h1234_5678, 64'h0);                   drain(40);

    for (int i = 0; i < 4; i++) begin
      rm = $urandom;
      rq = $urandom;
      launch(rm, rq, model(rm, rq));
      drain(40);
    end

    // Start during RUN and operand changes mid-run must not disturb the result.
    d0 = done_cnt;
    launch(32'd1000, 32'hFFFF_FFB3, model(32'd1000, 32'hFFFF_FFB3));
    repeat (4) @(negedge i_clk);
    i_multiplicand = 32'h0000_1111;
    i_multiplier   = 32'h0000_2222;
    i_start        = 1'b1;
    @(negedge i_clk);
    i_start        = 1'b0;
    i_multiplicand = 32'hDEAD_BEEF;
    i_multiplier   = 32'hCAFE_F00D;
    drain(40);
    repeat (36) @(negedge i_clk);
    check_val("single_done", 64'(done_cnt - d0), 64'd1);

    // Reset in the middle of RUN aborts with no done pulse.
    launch(32'h1234_5678, 32'h0765_4321, model(32'h1234_5678, 32'h0765_4321));
    repeat (9) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    exp_q.delete();
    acc_q.delete();
    check_val("abort_busy", {63'd0, o_busy}, 64'd0);
    check_val("abort_done", {63'd0, o_done}, 64'd0);
    check_val("abort_product", o_product, 64'd0);
    d0 = done_cnt;
    repeat (40) @(negedge i_clk);
    check_val("no_done_after_reset", 64'(done_cnt - d0), 64'd0);

    launch(32'd5, 32'd6, 64'd30); drain(40);

    // Reset and start together: reset wins.
    i_multiplicand = 32'd3;
    i_multiplier   = 32'd3;
    i_reset        = 1'b1;
    i_start        = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    i_start = 1'b0;
    check_val("rst_start_busy", {63'd0, o_busy}, 64'd0);
    @(negedge i_clk);
    check_val("rst_start_busy2", {63'd0, o_busy}, 64'd0);
    check_val("rst_start_done", {63'd0, o_done}, 64'd0);

    // Back-to-back: start held in the DONE cycle.
    launch(32'd4, 32'd5, 64'd20);
    n_wait = 0;
    while (!o_done && n_wait < 40) begin
      @(negedge i_clk);
      n_wait++;
    end
    if (!o_done) check_val("b2b_wait_timeout", 64'd0, 64'd1);
    launch(32'd2, 32'd3, 64'd6);
    drain(40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
